// File: rtl/dsp_db_pkg.sv
// Shared constants and types for the dB <-> linear power converters.
// DB_TO_POWER_INTERP_EN selects the interpolating (longer) antilog pipeline.
package dsp_db_pkg;

  localparam int K_LOG2_10_DIV10 = 21770;
  localparam int MANT_FRAC       = 15;

`ifdef DB_TO_POWER_INTERP_EN
  localparam int DB_TO_POWER_LATENCY = 5;
`else
  localparam int DB_TO_POWER_LATENCY = 4;
`endif

  typedef logic [15:0] db_q8_8_t;
  typedef logic [31:0] power_t;

  // Elaboration-time only: Q1.15 value of 2^(i / 2^lut_bits), rounded.
  function automatic logic [16:0] exp2_entry(input int i, input int lut_bits);
    real v;
    v = (2.0 ** (real'(i) / real'(1 << lut_bits))) * 32768.0;
    return 17'($rtoi(v + 0.5));
  endfunction

endpackage

// File: rtl/exp2_frac_lut.sv
// Combinational 2^f mantissa ROM with 2^LUT_BITS+1 entries; returns entries idx and idx+1.
module exp2_frac_lut
  import dsp_db_pkg::*;
#(
  parameter int LUT_BITS = 6
) (
  input  logic [LUT_BITS-1:0] idx,
  output logic [16:0]         entry_lo,
  output logic [16:0]         entry_hi
);

  logic [16:0] rom [0:(1 << LUT_BITS)];

  for (genvar i = 0; i <= (1 << LUT_BITS); i++) begin : g_rom
    localparam logic [16:0] ENTRY = exp2_entry(i, LUT_BITS);
    assign rom[i] = ENTRY;
  end

  assign entry_lo = rom[{1'b0, idx}];
  assign entry_hi = rom[{1'b0, idx} + (LUT_BITS + 1)'(1)];

endmodule

// File: rtl/db_to_power.sv
// Pipelined antilog: Q8.8 dB in, 32-bit linear power out (power = 10^(dB/10)).
// Define DB_TO_POWER_INTERP_EN to add a linear-interpolation stage on the mantissa.
module db_to_power
  import dsp_db_pkg::*;
#(
  parameter int LUT_BITS  = 6,
  parameter int FRAC_BITS = 12
) (
  input  logic     clk,
  input  logic     rst,
  input  db_q8_8_t dB_i,
  input  logic     valid_i,
  output power_t   power_o,
  output logic     sat_o,
  output logic     valid_o
);

  localparam int REM_BITS = FRAC_BITS - LUT_BITS;

  db_q8_8_t            s1_db;
  logic                s1_valid;
  logic [31:0]         s2_prod;
  logic                s2_valid;
  logic [7:0]          s3_n;
  logic [16:0]         s3_m0;
  logic                s3_valid;
  logic [LUT_BITS-1:0] lut_idx;
  logic [16:0]         lut_lo;
  logic [16:0]         lut_hi;
  logic [7:0]          fin_n;
  logic [16:0]         fin_m;
  logic                fin_valid;
  logic [47:0]         scaled;
  power_t              power_next;
  logic                sat_next;
  logic                unused_bits;

  // Q8.24 log2 value: integer exponent in [31:24], fraction below it.
  assign lut_idx     = s2_prod[23 -: LUT_BITS];
  assign unused_bits = ^{lut_hi, s2_prod[23-LUT_BITS:0]};

  exp2_frac_lut #(.LUT_BITS(LUT_BITS)) u_lut (
    .idx      (lut_idx),
    .entry_lo (lut_lo),
    .entry_hi (lut_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_db    <= '0;
      s1_valid <= 1'b0;
      s2_prod  <= '0;
      s2_valid <= 1'b0;
      s3_n     <= '0;
      s3_m0    <= '0;
      s3_valid <= 1'b0;
    end else begin
      s1_db    <= dB_i;
      s1_valid <= valid_i;
      s2_prod  <= 32'(s1_db) * 32'(K_LOG2_10_DIV10);
      s2_valid <= s1_valid;
      s3_n     <= s2_prod[31:24];
      s3_m0    <= lut_lo;
      s3_valid <= s2_valid;
    end
  end

`ifdef DB_TO_POWER_INTERP_EN
  logic [16:0]          s3_m1;
  logic [REM_BITS-1:0]  s3_rem;
  logic [16+REM_BITS:0] delta_prod;

  // Table slope is always non-negative, so the difference never wraps.
  assign delta_prod = (17 + REM_BITS)'(s3_m1 - s3_m0) * (17 + REM_BITS)'(s3_rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_m1     <= '0;
      s3_rem    <= '0;
      fin_n     <= '0;
      fin_m     <= '0;
      fin_valid <= 1'b0;
    end else begin
      s3_m1     <= lut_hi;
      s3_rem    <= s2_prod[23-LUT_BITS -: REM_BITS];
      fin_n     <= s3_n;
      fin_m     <= s3_m0 + 17'(delta_prod >> REM_BITS);
      fin_valid <= s3_valid;
    end
  end
`else
  assign fin_n     = s3_n;
  assign fin_m     = s3_m0;
  assign fin_valid = s3_valid;
`endif

  // Scale mantissa by 2^n; anything reaching bit 32 of the integer result saturates.
  always_comb begin
    scaled     = 48'(fin_m) << fin_n[4:0];
    power_next = 32'hFFFF_FFFF;
    sat_next   = 1'b1;
    if ((fin_n < 8'd32) && !scaled[MANT_FRAC+32]) begin
      power_next = scaled[MANT_FRAC+31:MANT_FRAC];
      sat_next   = 1'b0;
    end else begin
      power_next = 32'hFFFF_FFFF;
      sat_next   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      power_o <= '0;
      sat_o   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= fin_valid;
      if (fin_valid) begin
        power_o <= power_next;
        sat_o   <= sat_next;
      end else begin
        power_o <= power_o;
        sat_o   <= sat_o;
      end
    end
  end

endmodule

// File: tb/tb_db_to_power.sv
// Scoreboard bench for db_to_power: expected results are derived from 10^(dB/10).
module tb_db_to_power;
  import dsp_db_pkg::*;

  localparam real TWO32  = 4294967296.0;
  localparam real TOL_HI = 0.001;
`ifdef DB_TO_POWER_INTERP_EN
  localparam real    TOL_LO = 0.001;
  localparam longint R30_LO = 999;
  localparam longint R30_HI = 1001;
`else
  localparam real    TOL_LO = 0.012;
  localparam longint R30_LO = 988;
  localparam longint R30_HI = 1000;
`endif

  typedef struct {
    logic [15:0] db;
    int          issue;
    bit          has_range;
    longint      rlo;
    longint      rhi;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] dB_i;
  logic        valid_i;
  logic [31:0] power_o;
  logic        sat_o;
  logic        valid_o;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  db_to_power dut (
    .clk     (clk),
    .rst     (rst),
    .dB_i    (dB_i),
    .valid_i (valid_i),
    .power_o (power_o),
    .sat_o   (sat_o),
    .valid_o (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Compare one DUT result against the ideal antilog of the issued dB value.
  task automatic check_out(input exp_t e);
    real ideal;
    real lo;
    real hi;
    ideal = 10.0 ** (real'(e.db) / 2560.0);
    lo    = ideal * (1.0 - TOL_LO) - 1.0;
    hi    = ideal * (1.0 + TOL_HI) + 1.0;
    chk("latency", longint'(cyc), longint'(e.issue + DB_TO_POWER_LATENCY));
    if (ideal >= TWO32 * (1.0 + TOL_LO + 0.001)) begin
      chk("sat_required", longint'(sat_o), 1);
    end else if (ideal < TWO32 * 0.998) begin
      chk("sat_forbidden", longint'(sat_o), 0);
    end
    if (sat_o) begin
      chk("sat_value", longint'(power_o), 64'h0000_0000_FFFF_FFFF);
    end else begin
      total++;
      if (real'(power_o) < lo || real'(power_o) > hi) begin
        bad++;
        $display("FAIL tolerance db=%h actual=%0d required=%0.2f..%0.2f", e.db, power_o, lo, hi);
      end
    end
    if (e.has_range) chk_range("directed", longint'(power_o), e.rlo, e.rhi);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(posedge clk) begin
    #1;
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        check_out(sb.pop_front());
      end
    end
  end

  task automatic issue(input logic [15:0] d, input bit hr, input longint lo, input longint hi);
    exp_t e;
    e.db        = d;
    e.issue     = cyc;
    e.has_range = hr;
    e.rlo       = lo;
    e.rhi       = hi;
    sb.push_back(e);
    dB_i    = d;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", longint'(sb.size()), 0);
  endtask

  initial begin
    logic [15:0] d;
    rst     = 1'b1;
    valid_i = 1'b0;
    dB_i    = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_power", longint'(power_o), 0);
    chk("reset_sat", longint'(sat_o), 0);
    chk("reset_valid", longint'(valid_o), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h0000, 1'b1, 1, 1);
    drain();
    issue(16'h1E00, 1'b1, R30_LO, R30_HI);
    drain();
    issue(16'h5A00, 1'b0, 0, 0);
    issue(16'h6066, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    issue(16'hFFFF, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
    issue(16'h5FFF, 1'b0, 0, 0);
    issue(16'h6000, 1'b0, 0, 0);
    drain();

    issue(16'h0000, 1'b1, 1, 1);
    issue(16'h0303, 1'b0, 0, 0);
    issue(16'h0A00, 1'b0, 0, 0);
    issue(16'h1400, 1'b0, 0, 0);
    drain();

    // Three samples in flight, then a one-cycle reset must discard them.
    issue(16'h1E00, 1'b0, 0, 0);
    issue(16'h2800, 1'b0, 0, 0);
    issue(16'h3200, 1'b0, 0, 0);
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midreset_power", longint'(power_o), 0);
    chk("midreset_sat", longint'(sat_o), 0);
    chk("midreset_valid", longint'(valid_o), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(16'h1E00, 1'b1, R30_LO, R30_HI);
    drain();

    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 1) == 0) d = 16'($urandom_range(0, 25000));
      else d = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(d, 1'b0, 0, 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/db_to_power.md
Name: db_to_power

Overview:
- Antilog converter: turns an unsigned Q8.8 dB value into 32-bit linear power, i.e. power = 10^(dB/10).
- It is the inverse of the power-to-dB path in the DSP library.
- Uses: back-converting threshold/AGC set-points entered in dB, and bench round-trip checks of the receive chain.
- Fully pipelined: one conversion accepted per clock, fixed latency, valid-tagged.

Parameters:
- LUT_BITS, 6: log2 of the number of 2^f mantissa table entries (64).
- FRAC_BITS, 12: fraction bits of the log2-domain value kept after the multiply (≥ LUT_BITS).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- dB_i  in  16  unsigned Q8.8 dB value
- valid_i  in  1  dB_i valid this cycle
- power_o  out  32  unsigned linear power (integer)
- sat_o  out  1  result saturated; qualified by valid_o
- valid_o  out  1  power_o/sat_o valid this cycle

Behaviour:
- Reset: asynchronous, active-high. Every pipeline register, including valid bits, power_o and sat_o, clears to 0. Reset mid-stream drops all in-flight samples; no valid_o is produced for them.
- Pipeline, no stall and no backpressure; valid travels with data.
  - S1: register dB_i and valid_i.
  - S2: prod = dB × K, with K = 21770 (round(log2(10)/10 × 2^16)). This is a 16×16 unsigned multiply giving 32-bit Q8.24 log2 value x.
  - S3: split x.
    - n = prod[31:24]
    - f = prod[23:24-FRAC_BITS]
    - idx = f[FRAC_BITS-1 -: LUT_BITS]
    - rem = remaining low bits of f
    - Look up m0 = LUT[idx]. The LUT holds 17-bit Q1.15 values round(2^(i/2^LUT_BITS) × 32768), i = 0..2^LUT_BITS. Entry 2^LUT_BITS = 65536.
  - S4 (INTERP_EN only): mantissa interpolation, see Optional Feature.
  - Final stage:
    - If n ≥ 32: power_o = 32'hFFFF_FFFF, sat_o = 1.
    - Otherwise: compute (m × 2^n) >> 15 in 48-bit width and truncate. If the result exceeds 32'hFFFF_FFFF, saturate as above; else sat_o = 0.
- Latency from valid_i to valid_o: 4 cycles without INTERP_EN, 5 with. Expose it as a package constant.
- Throughput: 1 per clock. Back-to-back valid_i yields back-to-back valid_o in order.
- When valid_o = 0, power_o and sat_o hold their last values. Checkers ignore them.
- Boundaries:
  - dB_i = 0 → power_o = 1.
  - Any dB_i with n = 31 still fits unless the mantissa overflows 32 bits.
  - Maximum dB_i (0xFFFF) → saturated.
- Accuracy vs ideal 10^(dB/10), for non-saturated outputs ≥ 64:
  - without INTERP_EN: ≤ 1.2% low
  - with INTERP_EN: ≤ 0.1%

Optional Feature:
- Macro DB_TO_POWER_INTERP_EN.
- Defined: adds S4 linear interpolation, m = m0 + (((LUT[idx+1] − m0) × rem) >> (FRAC_BITS − LUT_BITS)). The S4 register is inserted and latency becomes 5.
- Undefined: m = m0 (truncating table lookup), no S4 register, latency 4, no extra multiplier.

Decomposition:
- Package dsp_db_pkg holds:
  - constant K_LOG2_10_DIV10 = 21770
  - constant MANT_FRAC = 15
  - DB_TO_POWER_LATENCY, derived from DB_TO_POWER_INTERP_EN
  - typedefs db_q8_8_t (16 bit) and power_t (32 bit)
- One sub-module, exp2_frac_lut: combinational ROM of 2^LUT_BITS+1 entries. Index in, returns the idx and idx+1 entries.

Test Plan:
- dB_i = 0x0000, valid 1 cycle → one valid_o after the configured latency; power_o = 1, sat_o = 0.
- dB_i = 0x1E00 (30.0 dB) → power_o within tolerance of 1000 (interp: 999..1001; no interp: 988..1000).
- dB_i = 0x5A00 (90.0 dB) → power_o ≈ 0x3B9ACA00 ±0.1% (interp) or ±1.2% (no interp); sat_o = 0. dB_i = 0x6066 (96.4 dB) → power_o = 0xFFFFFFFF, sat_o = 1.
- Stream dB_i = 0x0000, 0x0303, 0x0A00, 0x1400 on consecutive cycles → 4 consecutive valid_o in order: 1, 2, 10, 100 (±tolerance).
- Assert rst for 1 cycle while 3 samples are in flight → no valid_o for them; power_o = 0, sat_o = 0 immediately. The next sample after release converts correctly.
- Random sweep of 10k dB_i values against a 10^(dB/10) reference model → all within tolerance; saturation flagged exactly when the ideal result ≥ 2^32.
